sd_sector_writer: RTL and testbench
===================================

Name: sd_sector_writer

Overview:
- Write-side companion to the SD read path.
- Accepts a byte stream from upstream logic and buffers it into one 512-byte sector.
- Writes that sector to the card through sd_controller's write interface (wr, din, address, ready, ready_for_next_byte).
- Auto-increments the sector address so consecutive sectors land contiguously, e.g. for logging decoded data back to the card.

Parameters:
- START_ADDR, 32'h0000_0200, byte address of the first sector written after reset.
- SECTOR_BYTES, 512, bytes per sector; fixed by the SD protocol, do not override.
- PAD_BYTE, 8'h00, fill value for unwritten bytes of a flushed partial sector.

Ports:
- clk_in  input  1  system clock; all sd_* signals are synchronous to it.
- rst_in  input  1  asynchronous, active-high reset.
- data_in  input  8  upstream byte.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept a byte this cycle.
- flush_in  input  1  one-cycle pulse: pad the current partial sector and write it.
- sd_ready  input  1  sd_controller ready.
- sd_ready_for_next_byte  input  1  sd_controller requests the next write byte.
- sd_wr  output  1  write request to sd_controller.
- sd_din  output  8  byte to sd_controller.
- sd_addr  output  32  sector byte address to sd_controller.
- busy_out  output  1  high in any state other than FILL.
- sector_done_out  output  1  one-cycle pulse per completed sector.
- sectors_written_out  output  16  count of completed sectors; wraps.
- error_out  output  1  sticky: controller finished before 512 byte requests.

Behaviour:
- Reset (async, rst_in=1): state=FILL, fill_cnt=0, rd_ptr=0, pad_mode=0, cur_addr=START_ADDR.
  - Reset output values: ready_out=0 while reset is asserted, then 1 in FILL; sd_wr=0; sd_din=0; sd_addr=0; busy_out=0; sector_done_out=0; sectors_written_out=0; error_out=0.
  - Reset mid-write drops sd_wr immediately. The partial sector is discarded and no completion pulse is generated.
- Buffer: 512x8 inferred single-clock RAM with a 1-cycle read latency. sd_din is a register.
- Edge detect: rne = sd_ready_for_next_byte & ~prev. prev is registered every cycle.
- FILL:
  - ready_out=1.
  - On valid_in & ready_out: buf[fill_cnt] <= data_in; fill_cnt++.
  - Acceptance of byte 511 -> WAIT_RDY, ready_out=0 from the next cycle.
  - flush_in with fill_cnt>0 -> pad_mode=1, go to WAIT_RDY.
  - flush_in with fill_cnt==0 is ignored.
  - flush_in and an accepted byte in the same cycle: the byte is stored first and counted, then the flush applies.
  - If that accepted byte was byte 511, the flush is redundant and pad_mode stays 0.
- WAIT_RDY:
  - Prefetch buf[0] into sd_din.
  - When sd_ready=1 and the prefetch has completed (at least 2 cycles in state) -> ISSUE.
- ISSUE:
  - sd_wr=1, sd_addr=cur_addr.
  - Hold until sd_ready=0 is sampled. The next cycle: sd_wr=0, sd_addr=0, -> WRITE.
- WRITE:
  - On each rne with rd_ptr<511: rd_ptr++, and sd_din <= buf[rd_ptr+1] exactly 2 cycles after the rne.
  - If pad_mode and rd_ptr+1 >= fill_cnt, sd_din <= PAD_BYTE instead.
  - rne with rd_ptr==511: sd_din holds and the edge is counted toward the 512 total.
  - sd_ready rising (0->1):
    - After at least 512 rne edges: completion.
    - After fewer than 512 rne edges: completion and error_out<=1.
- Completion (one cycle):
  - sector_done_out=1, sectors_written_out++, cur_addr += 512 (32-bit wrap).
  - fill_cnt=0, rd_ptr=0, pad_mode=0, -> FILL.
- Throughput: no upstream bytes are accepted outside FILL; there is no double buffering.
- flush_in outside FILL is ignored.
- sd_addr is nonzero only while sd_wr=1.

Test Plan:
- Stream bytes 0x00..0xFF twice (512 bytes), then a behavioural controller model (after sd_wr, drops ready, 512 ready_for_next_byte pulses 8 cycles apart, sampling din on each rising edge, then ready=1) -> sd_addr=0x200 during sd_wr; model captures 0x00..0xFF,0x00..0xFF; one sector_done_out pulse; sectors_written_out=1; ready_out returns to 1.
- Two back-to-back full sectors -> second sd_addr=0x400; sectors_written_out=2; byte 512 of the stream is stalled (ready_out=0) until the first sector completes.
- 10 bytes 0xA0..0xA9, then flush_in -> sector written with those 10 bytes followed by 502 bytes of 0x00.
- flush_in with an empty buffer -> no sd_wr, busy_out stays 0.
- flush_in in the same cycle as byte 511 is accepted -> exactly one sector, no padding.
- Assert rst_in after 100 bytes of a write -> sd_wr=0 at once; counters are 0; the next sector goes to 0x200.
- Model returns ready=1 after 300 rne edges -> error_out=1 and stays 1; sector_done_out still pulses once.

Source files
------------

// File: rtl/sd_sector_writer_if.sv
// Write-side bus between the sector writer and sd_controller.
// The writer drives the request, byte and address; the controller returns the handshakes.
interface sd_sector_writer_if;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_addr;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;

  modport master (
    output sd_wr, sd_din, sd_addr,
    input  sd_ready, sd_ready_for_next_byte
  );

  modport slave (
    input  sd_wr, sd_din, sd_addr,
    output sd_ready, sd_ready_for_next_byte
  );
endinterface

// File: rtl/sd_sector_writer.sv
// Buffers an upstream byte stream into one 512-byte sector and writes it to sd_controller,
// advancing the card address by one sector after each completed write.
module sd_sector_writer #(
  parameter logic [31:0] START_ADDR   = 32'h0000_0200,
  parameter int unsigned SECTOR_BYTES = 512,
  parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 flush_in,
  sd_sector_writer_if.master   sd,
  output logic                 busy_out,
  output logic                 sector_done_out,
  output logic [15:0]          sectors_written_out,
  output logic                 error_out
);

  localparam int unsigned PW = $clog2(SECTOR_BYTES);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(SECTOR_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SECTOR_BYTES);

  typedef enum logic [1:0] {FILL, WAIT_RDY, ISSUE, WRITE} state_t;

  state_t        state, next_state;
  logic [CW-1:0] fill_cnt;
  logic [PW-1:0] rd_ptr;
  logic          pad_mode;
  logic [31:0]   cur_addr;
  logic [1:0]    wait_cnt;
  logic [CW-1:0] edge_cnt;
  logic          rnb_prev, rdy_prev;
  logic [7:0]    mem [SECTOR_BYTES];
  logic [7:0]    rd_data;
  logic          ld_q, pad_q;

  logic          accept_c, rne_c, rdy_rise_c, last_byte_c, flush_go_c, done_c;
  logic          rd_req_c, rd_pad_c;
  logic [PW-1:0] rd_addr_c;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= FILL;
    else        state <= next_state;
  end

  // Next state plus per-cycle control strobes.
  always_comb begin
    next_state  = state;
    accept_c    = valid_in & ready_out & (state == FILL);
    rne_c       = sd.sd_ready_for_next_byte & ~rnb_prev;
    rdy_rise_c  = sd.sd_ready & ~rdy_prev;
    last_byte_c = 1'b0;
    flush_go_c  = 1'b0;
    done_c      = 1'b0;
    rd_req_c    = 1'b0;
    rd_pad_c    = 1'b0;
    rd_addr_c   = '0;
    unique case (state)
      FILL: begin
        last_byte_c = accept_c && (fill_cnt == CW'(LAST_IDX));
        // A flush landing with the final byte is redundant: the sector is already full.
        flush_go_c  = flush_in && !last_byte_c && (accept_c || (fill_cnt != '0));
        if (last_byte_c || flush_go_c) next_state = WAIT_RDY;
      end
      WAIT_RDY: begin
        rd_req_c = (wait_cnt == 2'd0);
        if (sd.sd_ready && (wait_cnt == 2'd2)) next_state = ISSUE;
      end
      ISSUE: begin
        if (!sd.sd_ready) next_state = WRITE;
      end
      WRITE: begin
        if (rne_c && (rd_ptr != LAST_IDX)) begin
          rd_req_c  = 1'b1;
          rd_addr_c = rd_ptr + PW'(1);
          rd_pad_c  = pad_mode && ({1'b0, rd_addr_c} >= fill_cnt);
        end
        if (rdy_rise_c) begin
          done_c     = 1'b1;
          next_state = FILL;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // Sector buffer: one write port from upstream, registered read port toward the card.
  always_ff @(posedge clk_in) begin
    if (accept_c) mem[fill_cnt[PW-1:0]] <= data_in;
    rd_data <= mem[rd_addr_c];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fill_cnt            <= '0;
      rd_ptr              <= '0;
      pad_mode            <= 1'b0;
      cur_addr            <= START_ADDR;
      wait_cnt            <= '0;
      edge_cnt            <= '0;
      rnb_prev            <= 1'b0;
      rdy_prev            <= 1'b0;
      ld_q                <= 1'b0;
      pad_q               <= 1'b0;
      sd.sd_din           <= '0;
      sd.sd_wr            <= 1'b0;
      sd.sd_addr          <= '0;
      ready_out           <= 1'b0;
      busy_out            <= 1'b0;
      sector_done_out     <= 1'b0;
      sectors_written_out <= '0;
      error_out           <= 1'b0;
    end else begin
      rnb_prev        <= sd.sd_ready_for_next_byte;
      rdy_prev        <= sd.sd_ready;
      ready_out       <= (next_state == FILL);
      busy_out        <= (next_state != FILL);
      sd.sd_wr        <= (next_state == ISSUE);
      sd.sd_addr      <= (next_state == ISSUE) ? cur_addr : '0;
      sector_done_out <= done_c;

      // Second stage of the 2-cycle fetch: RAM output (or pad) into the byte register.
      ld_q  <= rd_req_c;
      pad_q <= rd_pad_c;
      if (ld_q) sd.sd_din <= pad_q ? PAD_BYTE : rd_data;

      if (accept_c)   fill_cnt <= fill_cnt + CW'(1);
      if (flush_go_c) pad_mode <= 1'b1;

      if (state != WAIT_RDY)      wait_cnt <= '0;
      else if (wait_cnt != 2'd2)  wait_cnt <= wait_cnt + 2'd1;

      if ((state == WRITE) && rne_c) begin
        if (rd_ptr != LAST_IDX)   rd_ptr   <= rd_ptr + PW'(1);
        if (edge_cnt != FULL_CNT) edge_cnt <= edge_cnt + CW'(1);
      end

      if (done_c) begin
        sectors_written_out <= sectors_written_out + 16'd1;
        cur_addr            <= cur_addr + 32'(SECTOR_BYTES);
        fill_cnt            <= '0;
        rd_ptr              <= '0;
        pad_mode            <= 1'b0;
        edge_cnt            <= '0;
        if (edge_cnt != FULL_CNT) error_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Bench for sd_sector_writer: random and directed byte streams, a behavioural SD controller,
// and a sector-level reference model of what should land on the card and where.
`timescale 1ns/1ps
module tb_sd_sector_writer;
  localparam logic [31:0] START = 32'h0000_0200;
  localparam int SB = 512;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  data_in;
  logic        valid_in, flush_in;
  logic        ready_out, busy_out, sector_done_out, error_out;
  logic [15:0] sectors_written_out;

  sd_sector_writer_if sd_if();

  sd_sector_writer dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .data_in             (data_in),
    .valid_in            (valid_in),
    .ready_out           (ready_out),
    .flush_in            (flush_in),
    .sd                  (sd_if),
    .busy_out            (busy_out),
    .sector_done_out     (sector_done_out),
    .sectors_written_out (sectors_written_out),
    .error_out           (error_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;
  int done_cnt = 0, busy_hits = 0, addr_viol = 0;
  int ctl_edges = SB;

  // Controller-side capture (one entry per finished transaction).
  logic [7:0]  cap_all[$];
  logic [31:0] cap_addr[$];
  int          cap_len[$];
  logic [7:0]  ctl_buf[$];
  logic [31:0] ctl_addr;
  bit          ctl_abort;

  // Reference model: bytes pending in the open sector, then closed sectors and their addresses.
  logic [7:0]  pend[$], exp_all[$];
  logic [31:0] exp_addr[$];
  int          exp_nsec = 0, chk_sec = 0, exp_off = 0, cap_off = 0, acc_done = 0;

  always @(posedge clk_in) begin
    if (sector_done_out === 1'b1) done_cnt++;
    if (busy_out === 1'b1) busy_hits++;
  end

  always @(negedge clk_in)
    if (sd_if.sd_addr !== 32'h0 && sd_if.sd_wr !== 1'b1) addr_viol++;

  // Behavioural sd_controller write side.
  initial begin
    sd_if.sd_ready = 1'b1;
    sd_if.sd_ready_for_next_byte = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      if (rst_in !== 1'b1 && sd_if.sd_wr === 1'b1) begin
        ctl_addr  = sd_if.sd_addr;
        ctl_abort = 1'b0;
        ctl_buf.delete();
        sd_if.sd_ready = 1'b0;
        for (int i = 0; i < ctl_edges && !ctl_abort; i++) begin
          repeat (4) @(posedge clk_in);
          #1;
          if (rst_in === 1'b1) ctl_abort = 1'b1;
          else begin
            ctl_buf.push_back(sd_if.sd_din);
            sd_if.sd_ready_for_next_byte = 1'b1;
            repeat (4) @(posedge clk_in);
            #1;
            sd_if.sd_ready_for_next_byte = 1'b0;
            if (rst_in === 1'b1) ctl_abort = 1'b1;
          end
        end
        if (!ctl_abort) begin
          repeat (4) @(posedge clk_in);
          #1;
          cap_addr.push_back(ctl_addr);
          cap_len.push_back(ctl_buf.size());
          foreach (ctl_buf[i]) cap_all.push_back(ctl_buf[i]);
        end
        ctl_buf.delete();
        sd_if.sd_ready_for_next_byte = 1'b0;
        sd_if.sd_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic void close_sector();
    while (pend.size() < SB) pend.push_back(8'h00);
    foreach (pend[i]) exp_all.push_back(pend[i]);
    exp_addr.push_back(START + 32'(exp_nsec) * 32'(SB));
    exp_nsec++;
    pend.delete();
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit fl);
    int t = 0;
    while (ready_out !== 1'b1 && t < 10000) begin tick(); t++; end
    if (t >= 10000) begin
      chk("accept_wait", 32'(ready_out), 32'd1);
      return;
    end
    data_in = b; valid_in = 1'b1; flush_in = fl;
    tick();
    acc_done = done_cnt;
    valid_in = 1'b0; flush_in = 1'b0;
    pend.push_back(b);
    if (pend.size() == SB) close_sector();
    if (fl && pend.size() > 0) close_sector();
  endtask

  task automatic pulse_flush();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    if (pend.size() > 0) close_sector();
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 12000) begin tick(); t++; end
    chk("done_wait", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_sector(input int len);
    int mism = 0;
    chk($sformatf("sec%0d_present", chk_sec), 32'(cap_addr.size() > chk_sec), 32'd1);
    if (cap_addr.size() <= chk_sec || exp_addr.size() <= chk_sec) return;
    chk($sformatf("sec%0d_addr", chk_sec), cap_addr[chk_sec], exp_addr[chk_sec]);
    chk($sformatf("sec%0d_len", chk_sec), 32'(cap_len[chk_sec]), 32'(len));
    for (int i = 0; i < len && i < cap_len[chk_sec]; i++)
      if (cap_all[cap_off + i] !== exp_all[exp_off + i]) mism++;
    chk($sformatf("sec%0d_bytes", chk_sec), 32'(mism), 32'd0);
    cap_off += cap_len[chk_sec];
    exp_off += SB;
    chk_sec++;
  endtask

  initial begin
    int base, n, len, bh;
    rst_in = 1'b1; data_in = '0; valid_in = 1'b0; flush_in = 1'b0;
    #3;
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_wr", 32'(sd_if.sd_wr), 32'd0);
    chk("rst_din", 32'(sd_if.sd_din), 32'd0);
    chk("rst_addr", sd_if.sd_addr, 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(sector_done_out), 32'd0);
    chk("rst_count", 32'(sectors_written_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    tick();
    chk("ready_after_rst", 32'(ready_out), 32'd1);

    // Incrementing pattern twice.
    for (int i = 0; i < SB; i++) push_byte(8'(i), 1'b0);
    wait_done(1);
    check_sector(SB);
    chk("t1_count", 32'(sectors_written_out), 32'd1);
    chk("t1_ready", 32'(ready_out), 32'd1);
    chk("t1_busy", 32'(busy_out), 32'd0);

    // Two back-to-back random sectors; byte 512 must wait for the first completion.
    base = done_cnt;
    for (int i = 0; i < 2 * SB; i++) begin
      push_byte(8'($urandom), 1'b0);
      if (i == SB - 1) chk("t2_stall_ready", 32'(ready_out), 32'd0);
      if (i == SB) chk("t2_b512_after_done", 32'(acc_done), 32'(base + 1));
    end
    wait_done(base + 2);
    check_sector(SB);
    check_sector(SB);
    chk("t2_count", 32'(sectors_written_out), 32'd3);

    // Short sector flushed and padded.
    for (int i = 0; i < 10; i++) push_byte(8'hA0 + 8'(i), 1'b0);
    pulse_flush();
    wait_done(base + 3);
    check_sector(SB);

    // Flush on an empty buffer does nothing.
    n = cap_addr.size();
    bh = busy_hits;
    pulse_flush();
    repeat (30) tick();
    chk("t4_busy", 32'(busy_hits - bh), 32'd0);
    chk("t4_no_write", 32'(cap_addr.size()), 32'(n));

    // Flush coinciding with the final byte: one unpadded sector.
    for (int i = 0; i < SB - 1; i++) push_byte(8'($urandom), 1'b0);
    push_byte(8'($urandom), 1'b1);
    wait_done(base + 4);
    check_sector(SB);
    repeat (40) tick();
    chk("t5_single", 32'(cap_addr.size()), 32'(chk_sec));
    chk("t5_done_once", 32'(done_cnt), 32'(base + 4));

    // Random-length sector with flush on its last byte.
    len = $urandom_range(200, 2);
    for (int i = 0; i < len - 1; i++) push_byte(8'($urandom), 1'b0);
    push_byte(8'($urandom), 1'b1);
    wait_done(base + 5);
    check_sector(SB);
    chk("t6_count", 32'(sectors_written_out), 32'd6);

    // Reset in the middle of the write phase.
    base = done_cnt;
    for (int i = 0; i < SB; i++) push_byte(8'($urandom), 1'b0);
    n = 0;
    while (ctl_buf.size() < 100 && n < 6000) begin tick(); n++; end
    chk("t7_reached_100", 32'(ctl_buf.size() >= 100), 32'd1);
    rst_in = 1'b1;
    #1;
    chk("t7_wr", 32'(sd_if.sd_wr), 32'd0);
    chk("t7_addr", sd_if.sd_addr, 32'd0);
    chk("t7_busy", 32'(busy_out), 32'd0);
    chk("t7_ready", 32'(ready_out), 32'd0);
    chk("t7_count", 32'(sectors_written_out), 32'd0);
    chk("t7_error", 32'(error_out), 32'd0);
    while (exp_all.size() > exp_off) void'(exp_all.pop_back());
    while (exp_addr.size() > chk_sec) void'(exp_addr.pop_back());
    pend.delete();
    exp_nsec = 0;
    repeat (10) tick();
    rst_in = 1'b0;
    tick();
    chk("t7_ready_after", 32'(ready_out), 32'd1);
    chk("t7_no_done", 32'(done_cnt), 32'(base));

    // Controller finishes early: error is raised, completion still pulses once.
    ctl_edges = 300;
    for (int i = 0; i < SB; i++) push_byte(8'($urandom), 1'b0);
    wait_done(base + 1);
    check_sector(300);
    chk("t8_addr", cap_addr[cap_addr.size() - 1], 32'h0000_0200);
    chk("t8_error", 32'(error_out), 32'd1);
    chk("t8_count", 32'(sectors_written_out), 32'd1);
    repeat (20) tick();
    chk("t8_done_once", 32'(done_cnt), 32'(base + 1));
    ctl_edges = SB;

    // Error stays sticky across a good sector; address keeps advancing.
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), 1'b0);
    pulse_flush();
    wait_done(base + 2);
    check_sector(SB);
    chk("t9_error_sticky", 32'(error_out), 32'd1);
    chk("t9_count", 32'(sectors_written_out), 32'd2);
    chk("addr_only_with_wr", 32'(addr_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
